xcorr_sop_detect: RTL and testbench

//  Upstream of the SOP filter. Turns the cross-correlator magnitude stream into a single-cycle SOP pulse
//  at each correlation peak. Also reports how many SOPs fell in the last fixed observation window.
//  sop drives the filter's isop input; n_sps drives the filter's n_sps gate input.

---
 rtl/xcorr_sop_detect.sv | 134 +++++++++++++
 tb/tb_xcorr_sop_detect.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_sop_detect.sv
// Cross-correlator peak picker: one-cycle SOP pulse per correlation peak,
// with post-peak holdoff and a per-window SOP count for the downstream filter.
module xcorr_sop_detect #(
    parameter int MAG_W       = 16,
    parameter int PEAK_SPAN   = 8,
    parameter int HOLDOFF     = 200,
    parameter int WINDOW_CLKS = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             corr_valid,
    input  logic [MAG_W-1:0] corr_mag,
    input  logic [MAG_W-1:0] threshold,
    output logic             sop,
    output logic [MAG_W-1:0] peak_mag,
    output logic [14:0]      n_sps,
    output logic             n_sps_upd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEAK,
        S_HOLD
    } state_t;

    // Last count value before the event fires, so the compare is on the
    // registered count and the pulse lands one edge after the final sample.
    localparam logic [7:0]  SPAN_END = 8'(PEAK_SPAN - 1);
    localparam logic [15:0] HOLD_END = 16'(HOLDOFF - 1);
    localparam logic [23:0] WIN_LAST = 24'(WINDOW_CLKS - 1);
    localparam logic [14:0] CNT_MAX  = 15'h7fff;

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   max_q, max_d;
    logic [7:0]         span_q, span_d;
    logic [15:0]        hold_q, hold_d;
    logic               sop_q, sop_d;
    logic [MAG_W-1:0]   peak_q, peak_d;
    logic [23:0]        win_q, win_d;
    logic [14:0]        sop_cnt_q, sop_cnt_d;
    logic [14:0]        sop_inc;
    logic [14:0]        n_sps_q, n_sps_d;
    logic               upd_q, upd_d;

    // Peak search FSM; only valid samples move it or its counters.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        span_d  = span_q;
        hold_d  = hold_q;
        sop_d   = 1'b0;
        peak_d  = peak_q;
        if (corr_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (corr_mag > threshold) begin
                        max_d   = corr_mag;
                        span_d  = '0;
                        state_d = S_PEAK;
                    end
                end
                S_PEAK: begin
                    if (corr_mag > max_q) begin
                        max_d  = corr_mag;
                        span_d = '0;
                    end else if (span_q == SPAN_END) begin
                        sop_d   = 1'b1;
                        peak_d  = max_q;
                        hold_d  = '0;
                        state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
                    end else begin
                        span_d = span_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_END) begin
                        state_d = S_IDLE;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Free-running window; a SOP on the closing cycle belongs to that window.
    always_comb begin
        win_d     = (win_q == WIN_LAST) ? '0 : win_q + 24'd1;
        n_sps_d   = n_sps_q;
        upd_d     = 1'b0;
        sop_inc   = (sop_cnt_q == CNT_MAX) ? sop_cnt_q
                                           : sop_cnt_q + {14'd0, sop_q};
        sop_cnt_d = sop_inc;
        if (win_q == WIN_LAST) begin
            n_sps_d   = sop_inc;
            upd_d     = 1'b1;
            sop_cnt_d = '0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            max_q     <= '0;
            span_q    <= '0;
            hold_q    <= '0;
            sop_q     <= 1'b0;
            peak_q    <= '0;
            win_q     <= '0;
            sop_cnt_q <= '0;
            n_sps_q   <= '0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            span_q    <= span_d;
            hold_q    <= hold_d;
            sop_q     <= sop_d;
            peak_q    <= peak_d;
            win_q     <= win_d;
            sop_cnt_q <= sop_cnt_d;
            n_sps_q   <= n_sps_d;
            upd_q     <= upd_d;
        end
    end

    assign sop       = sop_q;
    assign peak_mag  = peak_q;
    assign n_sps     = n_sps_q;
    assign n_sps_upd = upd_q;

endmodule

// File: tb/tb_xcorr_sop_detect.sv
// Scoreboard bench for xcorr_sop_detect: traces are built up front, a
// lookahead reference model predicts SOPs and window counts, a monitor checks.
module tb_xcorr_sop_detect;

    localparam int MAG_W       = 16;
    localparam int PEAK_SPAN   = 8;
    localparam int HOLDOFF     = 200;
    localparam int WINDOW_CLKS = 20000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             corr_valid = 1'b0;
    logic [MAG_W-1:0] corr_mag = '0;
    logic [MAG_W-1:0] threshold = 16'd100;
    logic             sop;
    logic [MAG_W-1:0] peak_mag;
    logic [14:0]      n_sps;
    logic             n_sps_upd;

    always #5 clk = ~clk;

    xcorr_sop_detect #(
        .MAG_W      (MAG_W),
        .PEAK_SPAN  (PEAK_SPAN),
        .HOLDOFF    (HOLDOFF),
        .WINDOW_CLKS(WINDOW_CLKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .corr_valid(corr_valid),
        .corr_mag  (corr_mag),
        .threshold (threshold),
        .sop       (sop),
        .peak_mag  (peak_mag),
        .n_sps     (n_sps),
        .n_sps_upd (n_sps_upd)
    );

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t sop_exp[$];
    ev_t upd_exp[$];
    bit  tv[$];
    int  tm[$];
    int  thr = 100;
    int  cyc = 0;
    bit  active = 1'b0;
    bit  prev_sop = 1'b0;
    int  checks = 0;
    int  errors = 0;
    ev_t me;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    task automatic put(input bit v, input int m);
        tv.push_back(v);
        tm.push_back(m);
    endtask

    task automatic lows(input int k);
        repeat (k) put(1'b1, $urandom_range(0, thr));
    endtask

    // A peak is confirmed once PEAK_SPAN further valid samples are all no
    // larger; a larger one becomes the new candidate. SOP appears the cycle
    // after the confirming sample; holdoff then swallows HOLDOFF valid
    // samples starting at the SOP cycle.
    function automatic void run_model();
        int n, i, pk, j, cnt, big, k, h, c;
        int sops[$];
        ev_t e;
        n = tv.size();
        i = 0;
        while (i < n) begin
            if (!tv[i] || tm[i] <= thr) begin
                i++;
                continue;
            end
            pk  = i;
            cnt = 0;
            j   = i;
            forever begin
                cnt = 0;
                big = -1;
                j   = pk + 1;
                while (j < n && cnt < PEAK_SPAN && big < 0) begin
                    if (tv[j]) begin
                        if (tm[j] > tm[pk]) big = j;
                        else cnt++;
                    end
                    j++;
                end
                if (big < 0) break;
                pk = big;
            end
            if (cnt < PEAK_SPAN) break;
            e.cyc = j;
            e.val = tm[pk];
            sop_exp.push_back(e);
            sops.push_back(j);
            k = j;
            h = 0;
            while (k < n && h < HOLDOFF) begin
                if (tv[k]) h++;
                k++;
            end
            i = k;
        end
        for (int b = WINDOW_CLKS - 1; b + 1 < n; b += WINDOW_CLKS) begin
            c = 0;
            foreach (sops[x]) begin
                if (sops[x] > b - WINDOW_CLKS && sops[x] <= b) c++;
            end
            e.cyc = b + 1;
            e.val = (c > 32767) ? 32767 : c;
            upd_exp.push_back(e);
        end
    endfunction

    task automatic play();
        active = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk);
            #1;
            rst        = 1'b0;
            corr_valid = tv[i];
            corr_mag   = 16'(tm[i]);
            cyc        = i;
        end
        @(negedge clk);
        #1;
        active     = 1'b0;
        corr_valid = 1'b0;
        chk("sop_queue_left", sop_exp.size(), 0);
        chk("upd_queue_left", upd_exp.size(), 0);
        while (sop_exp.size() > 0) begin
            me = sop_exp.pop_front();
            $display("FAIL sop_never_seen: expected at cycle %0d mag %0d",
                     me.cyc, me.val);
        end
        while (upd_exp.size() > 0) begin
            me = upd_exp.pop_front();
            $display("FAIL upd_never_seen: expected at cycle %0d n_sps %0d",
                     me.cyc, me.val);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_sop"}, int'(sop), 0);
        chk({tag, "_peak_mag"}, int'(peak_mag), 0);
        chk({tag, "_n_sps"}, int'(n_sps), 0);
        chk({tag, "_n_sps_upd"}, int'(n_sps_upd), 0);
    endtask

    // Monitor: compare every DUT pulse against the scoreboard head.
    always @(negedge clk) begin
        if (active && !rst) begin
            if (sop_exp.size() > 0 && sop_exp[0].cyc < cyc) begin
                me = sop_exp.pop_front();
                chk("sop_missed", -1, me.cyc);
            end
            if (sop) begin
                chk("sop_back_to_back", int'(prev_sop), 0);
                if (sop_exp.size() == 0) begin
                    chk("sop_unexpected", cyc, -1);
                end else begin
                    me = sop_exp.pop_front();
                    chk("sop_cycle", cyc, me.cyc);
                    chk("peak_mag", int'(peak_mag), me.val);
                end
            end
            prev_sop = sop;
            if (upd_exp.size() > 0 && upd_exp[0].cyc < cyc) begin
                me = upd_exp.pop_front();
                chk("upd_missed", -1, me.cyc);
            end
            if (n_sps_upd) begin
                if (upd_exp.size() == 0) begin
                    chk("upd_unexpected", cyc, -1);
                end else begin
                    me = upd_exp.pop_front();
                    chk("upd_cycle", cyc, me.cyc);
                    chk("n_sps", int'(n_sps), me.val);
                end
            end
        end
    end

    int len;
    bit rv;

    initial begin
        threshold = 16'(thr);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");

        // periodic peaks, one SOP per 1000 clks landing on cycle 999 mod
        // 1000, so every window boundary carries a SOP
        for (int b = 0; b < 60; b++) begin
            for (int k = 0; k < 1000; k++) begin
                put(1'b1, (k == 990) ? 500 :
                          (k == 989 || k == 991) ? 200 : 20);
            end
        end
        lows(300);

        // isolated peak on a ramp
        put(1'b1, 50);
        put(1'b1, 120);
        put(1'b1, 300);
        for (int k = 0; k < 12; k++) put(1'b1, 250 - k * 10);
        lows(300);

        // equal magnitudes: earliest wins
        put(1'b1, 200);
        put(1'b1, 300);
        put(1'b1, 300);
        put(1'b1, 300);
        put(1'b1, 250);
        lows(300);

        // double bump within span
        put(1'b1, 300);
        repeat (4) put(1'b1, 200);
        put(1'b1, 310);
        repeat (10) put(1'b1, 200);
        lows(300);

        // holdoff: second peak 150 after SOP ignored, third at 250 taken
        put(1'b1, 400);
        lows(158);
        put(1'b1, 380);
        lows(99);
        put(1'b1, 390);
        lows(300);

        // 50% valid duty; invalid cycles carry junk magnitudes
        for (int k = 0; k < 40; k++) begin
            put(1'b0, $urandom_range(0, 65535));
            put(1'b1, (k == 5) ? 500 : (k > 5 && k < 15) ? 450 - k : 30);
        end
        lows(300);

        // random bumps with random valid gaps
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                rv = ($urandom_range(0, 3) != 0);
                put(rv, rv ? $urandom_range(101, 130)
                           : $urandom_range(0, 65535));
            end
            len = $urandom_range(0, 400);
            for (int k = 0; k < len; k++) begin
                rv = ($urandom_range(0, 3) != 0);
                put(rv, rv ? $urandom_range(0, thr)
                           : $urandom_range(0, 65535));
            end
        end
        lows(300);

        // leave a candidate mid-search for the reset that follows
        lows(5);
        put(1'b1, 400);
        put(1'b1, 300);
        put(1'b1, 300);

        run_model();
        play();

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midpeak_reset");

        tv.delete();
        tm.delete();
        prev_sop = 1'b0;
        lows(30);
        put(1'b1, 350);
        put(1'b1, 340);
        lows(300);
        run_model();
        play();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
